// File: rtl/issue_scheduler_pkg.sv
// rtl/issue_scheduler_pkg.sv - shared pipeline types for the dual-issue scheduler
package issue_scheduler_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HOLD_B = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic regwr;
    logic mem;
    logic load;
    logic branch;
  } slot_flags_t;

  localparam slot_flags_t FLAGS_NONE = '0;

  // Only a load that actually writes a register can create a load-use bubble.
  function automatic logic writes_load(input slot_flags_t f);
    return f.load & f.regwr;
  endfunction

endpackage

// File: rtl/issue_scheduler_hazard_match.sv
// rtl/issue_scheduler_hazard_match.sv - one source operand against load and pair destinations
module hazard_match #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_ld0_dst,
  input  logic             i_ld0_valid,
  input  logic [REG_W-1:0] i_ld1_dst,
  input  logic             i_ld1_valid,
  input  logic [REG_W-1:0] i_pair_dst,
  input  logic             i_pair_valid,
  output logic             o_hazard
);

  function automatic logic hits(input logic [REG_W-1:0] src,
                                input logic [REG_W-1:0] dst,
                                input logic             valid);
    return valid && (src == dst) && (dst != '0);
  endfunction

  logic w_ld0_hit;
  logic w_ld1_hit;
  logic w_pair_hit;

  assign w_ld0_hit  = hits(i_src, i_ld0_dst, i_ld0_valid);
  assign w_ld1_hit  = hits(i_src, i_ld1_dst, i_ld1_valid);
  assign w_pair_hit = hits(i_src, i_pair_dst, i_pair_valid);
  assign o_hazard   = w_ld0_hit | w_ld1_hit | w_pair_hit;

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - in-order dual-issue scheduler with B-slot hold and load-use stall
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] rsA,
  input  logic [REG_W-1:0] rtA,
  input  logic [REG_W-1:0] dstA,
  input  logic [REG_W-1:0] rsB,
  input  logic [REG_W-1:0] rtB,
  input  logic [REG_W-1:0] dstB,
  input  logic             regwrA,
  input  logic             memA,
  input  logic             loadA,
  input  logic             branchA,
  input  logic             regwrB,
  input  logic             memB,
  input  logic             loadB,
  input  logic             branchB,
  input  logic             validB,
  input  logic             flush,
  output logic             issueA_valid,
  output logic             issueB_valid,
  output logic             issueA_from_held,
  output logic             stall
);

  sched_state_e r_state;
  sched_state_e w_state_next;

  logic [REG_W-1:0] r_hold_rs;
  logic [REG_W-1:0] r_hold_rt;
  logic [REG_W-1:0] r_hold_dst;
  slot_flags_t      r_hold_flags;

  logic [REG_W-1:0] r_ld0_dst;
  logic             r_ld0_valid;
  logic [REG_W-1:0] r_ld1_dst;
  logic             r_ld1_valid;

  slot_flags_t      w_flags_a;
  slot_flags_t      w_flags_b;
  slot_flags_t      w_lane_a_flags;
  logic [REG_W-1:0] w_lane_a_dst;

  logic w_a_rs_haz;
  logic w_a_rt_haz;
  logic w_b_rs_haz;
  logic w_b_rt_haz;
  logic w_h_rs_haz;
  logic w_h_rt_haz;

  logic w_a_load_use;
  logic w_b_blocked;
  logic w_h_load_use;
  logic w_pairable;
  logic w_capture;
  logic w_ld0_set;
  logic w_ld1_set;

  assign w_flags_a = '{regwr: regwrA, mem: memA, load: loadA, branch: branchA};
  assign w_flags_b = '{regwr: regwrB, mem: memB, load: loadB, branch: branchB};

  // Slot A only ever sees load-use; its pair input is tied off.
  hazard_match #(.REG_W(REG_W)) u_haz_a_rs (
    .i_src(rsA), .i_ld0_dst(r_ld0_dst), .i_ld0_valid(r_ld0_valid),
    .i_ld1_dst(r_ld1_dst), .i_ld1_valid(r_ld1_valid),
    .i_pair_dst('0), .i_pair_valid(1'b0), .o_hazard(w_a_rs_haz)
  );

  hazard_match #(.REG_W(REG_W)) u_haz_a_rt (
    .i_src(rtA), .i_ld0_dst(r_ld0_dst), .i_ld0_valid(r_ld0_valid),
    .i_ld1_dst(r_ld1_dst), .i_ld1_valid(r_ld1_valid),
    .i_pair_dst('0), .i_pair_valid(1'b0), .o_hazard(w_a_rt_haz)
  );

  hazard_match #(.REG_W(REG_W)) u_haz_b_rs (
    .i_src(rsB), .i_ld0_dst(r_ld0_dst), .i_ld0_valid(r_ld0_valid),
    .i_ld1_dst(r_ld1_dst), .i_ld1_valid(r_ld1_valid),
    .i_pair_dst(dstA), .i_pair_valid(regwrA), .o_hazard(w_b_rs_haz)
  );

  hazard_match #(.REG_W(REG_W)) u_haz_b_rt (
    .i_src(rtB), .i_ld0_dst(r_ld0_dst), .i_ld0_valid(r_ld0_valid),
    .i_ld1_dst(r_ld1_dst), .i_ld1_valid(r_ld1_valid),
    .i_pair_dst(dstA), .i_pair_valid(regwrA), .o_hazard(w_b_rt_haz)
  );

  hazard_match #(.REG_W(REG_W)) u_haz_h_rs (
    .i_src(r_hold_rs), .i_ld0_dst(r_ld0_dst), .i_ld0_valid(r_ld0_valid),
    .i_ld1_dst(r_ld1_dst), .i_ld1_valid(r_ld1_valid),
    .i_pair_dst('0), .i_pair_valid(1'b0), .o_hazard(w_h_rs_haz)
  );

  hazard_match #(.REG_W(REG_W)) u_haz_h_rt (
    .i_src(r_hold_rt), .i_ld0_dst(r_ld0_dst), .i_ld0_valid(r_ld0_valid),
    .i_ld1_dst(r_ld1_dst), .i_ld1_valid(r_ld1_valid),
    .i_pair_dst('0), .i_pair_valid(1'b0), .o_hazard(w_h_rt_haz)
  );

  assign w_a_load_use = w_a_rs_haz | w_a_rt_haz;
  assign w_h_load_use = w_h_rs_haz | w_h_rt_haz;
  // B is blocked by either a dependency on A or a load-use on older loads.
  assign w_b_blocked  = w_b_rs_haz | w_b_rt_haz;
  assign w_pairable   = validB & ~w_b_blocked & ~(memA & memB) & ~branchB;

  always_comb begin
    in_ready         = 1'b0;
    issueA_valid     = 1'b0;
    issueB_valid     = 1'b0;
    issueA_from_held = 1'b0;
    stall            = 1'b0;
    w_capture        = 1'b0;
    w_state_next     = r_state;
    if (reset) begin
      w_state_next = ST_RUN;
    end else if (flush) begin
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (in_valid) begin
            if (w_a_load_use) begin
              stall = 1'b1;
            end else begin
              issueA_valid = 1'b1;
              in_ready     = 1'b1;
              if (w_pairable) begin
                issueB_valid = 1'b1;
              end else if (validB) begin
                w_capture    = 1'b1;
                w_state_next = ST_HOLD_B;
              end
            end
          end
        end
        ST_HOLD_B: begin
          if (w_h_load_use) begin
            stall = 1'b1;
          end else begin
            issueA_valid     = 1'b1;
            issueA_from_held = 1'b1;
            w_state_next     = ST_RUN;
          end
        end
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  assign w_lane_a_flags = issueA_from_held ? r_hold_flags : w_flags_a;
  assign w_lane_a_dst   = issueA_from_held ? r_hold_dst : dstA;
  // Non-issue cycles (stall, idle, flush) naturally clear both LD registers.
  assign w_ld0_set      = issueA_valid & writes_load(w_lane_a_flags);
  assign w_ld1_set      = issueB_valid & writes_load(w_flags_b);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RUN;
      r_hold_rs    <= '0;
      r_hold_rt    <= '0;
      r_hold_dst   <= '0;
      r_hold_flags <= FLAGS_NONE;
      r_ld0_dst    <= '0;
      r_ld0_valid  <= 1'b0;
      r_ld1_dst    <= '0;
      r_ld1_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ld0_valid <= w_ld0_set;
      r_ld0_dst   <= w_ld0_set ? w_lane_a_dst : '0;
      r_ld1_valid <= w_ld1_set;
      r_ld1_dst   <= w_ld1_set ? dstB : '0;
      if (flush) begin
        r_hold_rs    <= '0;
        r_hold_rt    <= '0;
        r_hold_dst   <= '0;
        r_hold_flags <= FLAGS_NONE;
      end else if (w_capture) begin
        r_hold_rs    <= rsB;
        r_hold_rt    <= rtB;
        r_hold_dst   <= dstB;
        r_hold_flags <= w_flags_b;
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - self-checking bench for issue_scheduler with a queue-based reference model
module tb_issue_scheduler;

  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready;
  logic [RW-1:0] rsA, rtA, dstA, rsB, rtB, dstB;
  logic regwrA, memA, loadA, branchA;
  logic regwrB, memB, loadB, branchB, validB;
  logic flush;
  logic issueA_valid, issueB_valid, issueA_from_held, stall;

  issue_scheduler #(.REG_W(RW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rsA(rsA), .rtA(rtA), .dstA(dstA), .rsB(rsB), .rtB(rtB), .dstB(dstB),
    .regwrA(regwrA), .memA(memA), .loadA(loadA), .branchA(branchA),
    .regwrB(regwrB), .memB(memB), .loadB(loadB), .branchB(branchB),
    .validB(validB), .flush(flush),
    .issueA_valid(issueA_valid), .issueB_valid(issueB_valid),
    .issueA_from_held(issueA_from_held), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs; int rt; int dst;
    bit regwr; bit mem; bit load; bit branch;
  } ins_t;

  ins_t cur_a, cur_b;
  bit   cur_vb, cur_iv, cur_fl, cur_rst;
  ins_t held_q[$];
  int   ld_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Output vector order: {in_ready, issueA, issueB, from_held, stall}
  function automatic logic [4:0] outs();
    return {in_ready, issueA_valid, issueB_valid, issueA_from_held, stall};
  endfunction

  function automatic ins_t mk(int rs, int rt, int dst, bit regwr, bit mem, bit load, bit branch);
    ins_t x;
    x.rs = rs; x.rt = rt; x.dst = dst;
    x.regwr = regwr; x.mem = mem; x.load = load; x.branch = branch;
    return x;
  endfunction

  function automatic bit reads(ins_t x, int d);
    return (d != 0) && (x.rs == d || x.rt == d);
  endfunction

  function automatic bit load_use(ins_t x);
    foreach (ld_q[i]) if (reads(x, ld_q[i])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] model_eval();
    bit pairable;
    if (cur_rst || cur_fl) return 5'b00000;
    if (held_q.size() > 0) return load_use(held_q[0]) ? 5'b00001 : 5'b01010;
    if (!cur_iv) return 5'b00000;
    if (load_use(cur_a)) return 5'b00001;
    if (!cur_vb) return 5'b11000;
    pairable = !(cur_a.regwr && reads(cur_b, cur_a.dst)) && !(cur_a.mem && cur_b.mem) && !cur_b.branch;
    if (pairable && !load_use(cur_b)) return 5'b11100;
    return 5'b11000;
  endfunction

  task automatic model_commit(input logic [4:0] e);
    ins_t lane;
    if (cur_rst || cur_fl) begin
      held_q.delete();
      ld_q.delete();
      return;
    end
    lane = e[1] ? held_q[0] : cur_a;
    ld_q.delete();
    if (e[3] && lane.load && lane.regwr) ld_q.push_back(lane.dst);
    if (e[2] && cur_b.load && cur_b.regwr) ld_q.push_back(cur_b.dst);
    if (e[1]) held_q.delete();
    else if (e[3] && cur_vb && !e[2]) held_q.push_back(cur_b);
  endtask

  task automatic drive(input ins_t a, input ins_t b, input bit vb, input bit iv, input bit fl);
    cur_a = a; cur_b = b; cur_vb = vb; cur_iv = iv; cur_fl = fl;
    rsA = a.rs[RW-1:0]; rtA = a.rt[RW-1:0]; dstA = a.dst[RW-1:0];
    rsB = b.rs[RW-1:0]; rtB = b.rt[RW-1:0]; dstB = b.dst[RW-1:0];
    regwrA = a.regwr; memA = a.mem; loadA = a.load; branchA = a.branch;
    regwrB = b.regwr; memB = b.mem; loadB = b.load; branchB = b.branch;
    validB = vb; in_valid = iv; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit(model_eval());
    #1;
  endtask

  ins_t nop, add_a, add_b, dep_b;

  task automatic test_reset();
    reset = 1'b1; cur_rst = 1'b1;
    drive(add_a, add_b, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b00000) begin
      $display("FAIL reset_outputs got=%b exp=%b", outs(), 5'b00000); tests_failed++;
    end
    tick();
    reset = 1'b0; cur_rst = 1'b0;
    drive(nop, nop, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b00000) begin
      $display("FAIL idle_after_reset got=%b exp=%b", outs(), 5'b00000); tests_failed++;
    end
    tick();
  endtask

  task automatic test_independent_pair();
    drive(add_a, add_b, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11100) begin
      $display("FAIL indep_pair got=%b exp=%b", outs(), 5'b11100); tests_failed++;
    end
    tick();
  endtask

  task automatic test_split(input string name, input ins_t a, input ins_t b);
    drive(a, b, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11000) begin
      $display("FAIL %s_c0 got=%b exp=%b", name, outs(), 5'b11000); tests_failed++;
    end
    tick();
    drive(add_a, add_b, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b01010) begin
      $display("FAIL %s_c1 got=%b exp=%b", name, outs(), 5'b01010); tests_failed++;
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11100) begin
      $display("FAIL %s_c2 got=%b exp=%b", name, outs(), 5'b11100); tests_failed++;
    end
    tick();
  endtask

  task automatic test_load_use();
    drive(mk(1, 2, 8, 1, 1, 1, 0), nop, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11000) begin
      $display("FAIL lw_issue got=%b exp=%b", outs(), 5'b11000); tests_failed++;
    end
    tick();
    drive(mk(8, 2, 9, 1, 0, 0, 0), nop, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b00001) begin
      $display("FAIL lw_use_stall got=%b exp=%b", outs(), 5'b00001); tests_failed++;
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11000) begin
      $display("FAIL lw_use_after got=%b exp=%b", outs(), 5'b11000); tests_failed++;
    end
    tick();
    // held B that depends on a load in A stalls once before issuing
    drive(mk(1, 2, 3, 1, 1, 1, 0), mk(3, 4, 5, 1, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11000) begin
      $display("FAIL held_lu_c0 got=%b exp=%b", outs(), 5'b11000); tests_failed++;
    end
    tick();
    drive(nop, nop, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b00001) begin
      $display("FAIL held_lu_c1 got=%b exp=%b", outs(), 5'b00001); tests_failed++;
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b01010) begin
      $display("FAIL held_lu_c2 got=%b exp=%b", outs(), 5'b01010); tests_failed++;
    end
    tick();
  endtask

  task automatic test_flush_hold();
    drive(add_a, dep_b, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11000) begin
      $display("FAIL flush_c0 got=%b exp=%b", outs(), 5'b11000); tests_failed++;
    end
    tick();
    drive(add_a, add_b, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b00000) begin
      $display("FAIL flush_c1 got=%b exp=%b", outs(), 5'b00000); tests_failed++;
    end
    tick();
    drive(add_a, add_b, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11100) begin
      $display("FAIL flush_c2 got=%b exp=%b", outs(), 5'b11100); tests_failed++;
    end
    tick();
  endtask

  task automatic test_async_reset();
    drive(add_a, dep_b, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11000) begin
      $display("FAIL areset_c0 got=%b exp=%b", outs(), 5'b11000); tests_failed++;
    end
    tick();
    #2;
    reset = 1'b1; cur_rst = 1'b1;
    #1;
    tests_run++;
    if (outs() !== 5'b00000) begin
      $display("FAIL areset_immediate got=%b exp=%b", outs(), 5'b00000); tests_failed++;
    end
    drive(nop, nop, 1'b0, 1'b0, 1'b0);
    tick();
    #3;
    reset = 1'b0; cur_rst = 1'b0;
    tick();
    drive(add_a, add_b, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11100) begin
      $display("FAIL areset_run got=%b exp=%b", outs(), 5'b11100); tests_failed++;
    end
    tick();
  endtask

  task automatic test_zero_reg();
    drive(mk(1, 2, 0, 1, 0, 0, 0), mk(0, 0, 4, 1, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11100) begin
      $display("FAIL zero_pair got=%b exp=%b", outs(), 5'b11100); tests_failed++;
    end
    tick();
    drive(mk(1, 2, 0, 1, 1, 1, 0), nop, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    tick();
    drive(mk(0, 0, 5, 1, 0, 0, 0), nop, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (outs() !== 5'b11000) begin
      $display("FAIL zero_load_use got=%b exp=%b", outs(), 5'b11000); tests_failed++;
    end
    tick();
  endtask

  function automatic ins_t rand_ins();
    ins_t x;
    bit ld;
    ld = ($urandom_range(0, 3) == 0);
    x = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           ld || ($urandom_range(0, 3) != 0), ld || ($urandom_range(0, 4) == 0),
           ld, ($urandom_range(0, 6) == 0));
    return x;
  endfunction

  task automatic test_random();
    logic [4:0] exp_v;
    for (int n = 0; n < 400; n++) begin
      drive(rand_ins(), rand_ins(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 8, $urandom_range(0, 24) == 0);
      @(negedge clk);
      exp_v = model_eval();
      tests_run++;
      if (outs() !== exp_v) begin
        $display("FAIL random_cycle%0d got=%b exp=%b", n, outs(), exp_v); tests_failed++;
      end
      tick();
    end
  endtask

  initial begin
    nop   = mk(0, 0, 0, 0, 0, 0, 0);
    add_a = mk(1, 2, 3, 1, 0, 0, 0);
    add_b = mk(4, 5, 6, 1, 0, 0, 0);
    dep_b = mk(3, 5, 6, 1, 0, 0, 0);
    test_reset();
    test_independent_pair();
    test_split("dep", add_a, dep_b);
    test_split("mem2", mk(1, 2, 3, 0, 1, 0, 0), mk(4, 5, 0, 0, 1, 0, 0));
    test_split("brB", add_a, mk(4, 5, 0, 0, 0, 0, 1));
    test_load_use();
    test_flush_hold();
    test_async_reset();
    test_zero_reg();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
